// File: rtl/rpn_exec_controller.sv
// RPN expression evaluator: operand stack, one-cycle ALU for add/sub/mul,
// a restoring divider (one quotient bit per cycle) and a held result
// handshake. Any fault in an expression raises a sticky flag that is
// reported at end-of-line and cleared by the result handshake.
module rpn_exec_controller #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   num_ready,
   input  logic [WIDTH-1:0]       num,
   input  logic                   op_ready,
   input  logic [3:0]             op,
   output logic                   tok_ready,
   output logic [WIDTH-1:0]       result,
   output logic                   result_valid,
   input  logic                   result_ready,
   output logic                   error,
   output logic [$clog2(DEPTH):0] depth
);

   localparam int DW = $clog2(DEPTH) + 1;
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(WIDTH) + 1;

   localparam logic [3:0] OP_MUL = 4'd2;
   localparam logic [3:0] OP_DIV = 4'd3;
   localparam logic [3:0] OP_EOL = 4'd4;

   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DIV, S_EMIT} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] stack_q [DEPTH];
   logic [DW-1:0]    depth_q, depth_d;
   logic             err_q, err_d;
   logic [1:0]       op_q, op_d;
   logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             error_q, error_d;

   logic             wr_en;
   logic [PW-1:0]    wr_idx;
   logic [WIDTH-1:0] wr_data;
   logic [WIDTH-1:0] alu;

   // Stack addressing: b is the top entry, a the one below it.
   logic [PW-1:0]    top_idx, below_idx, push_idx;
   logic [WIDTH-1:0] a_val, b_val;
   assign top_idx   = PW'(depth_q - DW'(1));
   assign below_idx = PW'(depth_q - DW'(2));
   assign push_idx  = PW'(depth_q);
   assign b_val     = stack_q[top_idx];
   assign a_val     = stack_q[below_idx];

   // Token decode in IDLE; an operator arriving with a number is dropped.
   logic has_two, is_full, op_only, in_idle;
   logic start_exec, start_div, div_by_zero, start_emit, div_last, overrun;
   assign in_idle     = (state_q == S_IDLE);
   assign has_two     = (depth_q >= DW'(2));
   assign is_full     = (depth_q == DW'(DEPTH));
   assign op_only     = op_ready && !num_ready;
   assign start_exec  = in_idle && op_only && (op <= OP_MUL) && has_two;
   assign start_div   = in_idle && op_only && (op == OP_DIV) && has_two && (b_val != '0);
   assign div_by_zero = in_idle && op_only && (op == OP_DIV) && has_two && (b_val == '0);
   assign start_emit  = in_idle && op_only && (op == OP_EOL);
   assign div_last    = (state_q == S_DIV) && (cnt_q == CW'(WIDTH - 1));
   assign overrun     = !in_idle && (num_ready || op_ready);

   // Restoring divide step: shift in the next dividend bit, subtract if it fits.
   logic [WIDTH:0]   div_shift;
   logic             div_ge;
   logic [WIDTH-1:0] div_rem_nx, div_quo_nx;
   assign div_shift  = {rem_q, quo_q[WIDTH-1]};
   assign div_ge     = (div_shift >= {1'b0, dvs_q});
   assign div_rem_nx = div_ge ? WIDTH'(div_shift - {1'b0, dvs_q}) : div_shift[WIDTH-1:0];
   assign div_quo_nx = {quo_q[WIDTH-2:0], div_ge};

   // Single-cycle ALU for the EXEC state; all results wrap modulo 2^WIDTH.
   always_comb begin
      unique case (op_q)
         2'd0:    alu = a_val + b_val;
         2'd1:    alu = a_val - b_val;
         default: alu = a_val * b_val;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values; combinational blocks use blocking ones.
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic.
   always_comb begin
      // NOTE: a default on entry to every combinational block keeps each
      // output assigned on all paths, so no latch is inferred.
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (start_exec)      state_d = S_EXEC;
            else if (start_div)  state_d = S_DIV;
            else if (start_emit) state_d = S_EMIT;
         end
         S_EXEC:  state_d = S_IDLE;
         S_DIV:   if (div_last) state_d = S_IDLE;
         S_EMIT:  if (result_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs decoded from state and held result registers.
   always_comb begin
      tok_ready    = (state_q == S_IDLE);
      result_valid = (state_q == S_EMIT);
      result       = result_q;
      error        = error_q;
      depth        = depth_q;
   end

   // Datapath next values: stack pointer, sticky error, divider, result.
   always_comb begin
      depth_d  = depth_q;
      err_d    = err_q;
      op_d     = op_q;
      rem_d    = rem_q;
      quo_d    = quo_q;
      dvs_d    = dvs_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      error_d  = error_q;
      wr_en    = 1'b0;
      wr_idx   = push_idx;
      wr_data  = num;
      unique case (state_q)
         S_IDLE: begin
            if (num_ready) begin
               if (op_ready) err_d = 1'b1;
               if (is_full) begin
                  err_d = 1'b1;
               end else begin
                  wr_en   = 1'b1;
                  depth_d = depth_q + DW'(1);
               end
            end else if (op_ready) begin
               if (start_exec) begin
                  op_d = op[1:0];
               end else if (start_div) begin
                  quo_d = a_val;
                  dvs_d = b_val;
                  rem_d = '0;
                  cnt_d = '0;
               end else if (div_by_zero) begin
                  err_d   = 1'b1;
                  wr_en   = 1'b1;
                  wr_idx  = below_idx;
                  wr_data = '0;
                  depth_d = depth_q - DW'(1);
               end else if (start_emit) begin
                  if ((depth_q == DW'(1)) && !err_q) begin
                     result_d = b_val;
                     error_d  = 1'b0;
                  end else begin
                     result_d = '0;
                     error_d  = 1'b1;
                  end
               end else begin
                  // Underflow on a binary operator or a reserved code.
                  err_d = 1'b1;
               end
            end
         end
         S_EXEC: begin
            wr_en   = 1'b1;
            wr_idx  = below_idx;
            wr_data = alu;
            depth_d = depth_q - DW'(1);
         end
         S_DIV: begin
            rem_d = div_rem_nx;
            quo_d = div_quo_nx;
            cnt_d = cnt_q + CW'(1);
            if (div_last) begin
               wr_en   = 1'b1;
               wr_idx  = below_idx;
               wr_data = div_quo_nx;
               depth_d = depth_q - DW'(1);
            end
         end
         S_EMIT: begin
            if (result_ready) begin
               depth_d = '0;
               err_d   = 1'b0;
            end
         end
         default: ;
      endcase
      // A dropped token is always flagged, even on the handshake edge.
      if (overrun) err_d = 1'b1;
   end

   // Datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         depth_q  <= '0;
         err_q    <= 1'b0;
         op_q     <= '0;
         rem_q    <= '0;
         quo_q    <= '0;
         dvs_q    <= '0;
         cnt_q    <= '0;
         result_q <= '0;
         error_q  <= 1'b0;
      end else begin
         depth_q  <= depth_d;
         err_q    <= err_d;
         op_q     <= op_d;
         rem_q    <= rem_d;
         quo_q    <= quo_d;
         dvs_q    <= dvs_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
         error_q  <= error_d;
      end
   end

   // Stack storage write port.
   always_ff @(posedge clk) begin
      // NOTE: the stack array has no reset; depth_q alone marks which entries
      // are live, so stale contents are never observed.
      if (wr_en) stack_q[wr_idx] <= wr_data;
   end

endmodule

// File: tb/tb_rpn_exec_controller.sv
// Directed bench for rpn_exec_controller: expected end-of-line results are
// queued when EOL is driven and popped when result_valid appears.
module tb_rpn_exec_controller;

   localparam int WIDTH = 16;
   localparam int DEPTH = 8;

   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_SUB = 4'd1;
   localparam logic [3:0] OP_MUL = 4'd2;
   localparam logic [3:0] OP_DIV = 4'd3;
   localparam logic [3:0] OP_EOL = 4'd4;
   localparam logic [3:0] OP_RSV = 4'd9;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             num_ready = 1'b0;
   logic [WIDTH-1:0] num = '0;
   logic             op_ready = 1'b0;
   logic [3:0]       op = '0;
   logic             result_ready = 1'b0;
   logic             tok_ready;
   logic [WIDTH-1:0] result;
   logic             result_valid;
   logic             error;
   logic [3:0]       depth;

   typedef struct packed {
      logic [WIDTH-1:0] res;
      logic             err;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   gap    = 20;

   always #5 clk = ~clk;

   rpn_exec_controller #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .num_ready    (num_ready),
      .num          (num),
      .op_ready     (op_ready),
      .op           (op),
      .tok_ready    (tok_ready),
      .result       (result),
      .result_valid (result_valid),
      .result_ready (result_ready),
      .error        (error),
      .depth        (depth)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
      end
   endtask

   task automatic send_num(input logic [WIDTH-1:0] v);
      @(negedge clk);
      num       = v;
      num_ready = 1'b1;
      @(negedge clk);
      num_ready = 1'b0;
      repeat (gap - 1) @(negedge clk);
   endtask

   task automatic send_op(input logic [3:0] c);
      @(negedge clk);
      op       = c;
      op_ready = 1'b1;
      @(negedge clk);
      op_ready = 1'b0;
      repeat (gap - 1) @(negedge clk);
   endtask

   task automatic send_eol(input logic [WIDTH-1:0] res, input logic err);
      exp_t e;
      e.res = res;
      e.err = err;
      exp_q.push_back(e);
      send_op(OP_EOL);
   endtask

   // Wait for a result, compare with the scoreboard, optionally stall, then handshake.
   task automatic collect(input string tag, input int hold);
      exp_t e;
      int   n = 0;
      while (result_valid !== 1'b1 && n < 300) begin
         @(negedge clk);
         n++;
      end
      e = exp_q.pop_front();
      checks++;
      assert (result_valid === 1'b1) else begin
         errors++;
         $error("FAIL %s_valid_timeout observed=%b expected=1", tag, result_valid);
      end
      if (result_valid === 1'b1) begin
         check({tag, "_result"}, 32'(result), 32'(e.res));
         check({tag, "_error"}, 32'(error), 32'(e.err));
         check({tag, "_tok_ready_busy"}, 32'(tok_ready), 32'd0);
         for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, "_hold_valid"}, 32'(result_valid), 32'd1);
            check({tag, "_hold_result"}, 32'(result), 32'(e.res));
            check({tag, "_hold_error"}, 32'(error), 32'(e.err));
         end
         result_ready = 1'b1;
         @(negedge clk);
         result_ready = 1'b0;
         check({tag, "_post_valid"}, 32'(result_valid), 32'd0);
         check({tag, "_post_depth"}, 32'(depth), 32'd0);
         check({tag, "_post_tok_ready"}, 32'(tok_ready), 32'd1);
      end
      repeat (2) @(negedge clk);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired before end of sequence");
      $fatal(1, "watchdog");
   end

   initial begin
      bit seen_valid;

      // Reset values while rst_n is held low.
      repeat (3) @(negedge clk);
      check("rst_tok_ready", 32'(tok_ready), 32'd1);
      check("rst_result_valid", 32'(result_valid), 32'd0);
      check("rst_result", 32'(result), 32'd0);
      check("rst_error", 32'(error), 32'd0);
      check("rst_depth", 32'(depth), 32'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // 12 12 add 3 mul 2 div EOL, tokens spaced 100 cycles.
      gap = 100;
      send_num(16'd12);
      send_num(16'd12);
      check("seq1_depth_two", 32'(depth), 32'd2);
      send_op(OP_ADD);
      check("seq1_depth_after_add", 32'(depth), 32'd1);
      send_num(16'd3);
      send_op(OP_MUL);
      send_num(16'd2);
      send_op(OP_DIV);
      check("seq1_depth_after_div", 32'(depth), 32'd1);
      send_eol(16'h0024, 1'b0);
      collect("seq1", 0);
      gap = 20;

      // Wrapping subtract and truncated multiply.
      send_num(16'd5);
      send_num(16'd7);
      send_op(OP_SUB);
      send_eol(16'hFFFE, 1'b0);
      collect("sub_wrap", 0);
      send_num(16'd65535);
      send_num(16'd2);
      send_op(OP_MUL);
      send_eol(16'hFFFE, 1'b0);
      collect("mul_trunc", 0);

      // Divide by zero, then a clean divide proves the flag was cleared.
      send_num(16'd9);
      send_num(16'd0);
      send_op(OP_DIV);
      check("div0_depth", 32'(depth), 32'd1);
      send_eol(16'd0, 1'b1);
      collect("div0", 0);
      send_num(16'd8);
      send_num(16'd2);
      send_op(OP_DIV);
      send_eol(16'd4, 1'b0);
      collect("div_8_2", 0);

      // Further divider patterns.
      send_num(16'd100);
      send_num(16'd7);
      send_op(OP_DIV);
      send_eol(16'd14, 1'b0);
      collect("div_100_7", 0);
      send_num(16'd65535);
      send_num(16'd255);
      send_op(OP_DIV);
      send_eol(16'd257, 1'b0);
      collect("div_ffff_255", 0);

      // Underflow: operator on an empty stack.
      send_op(OP_ADD);
      check("underflow_depth", 32'(depth), 32'd0);
      send_eol(16'd0, 1'b1);
      collect("underflow", 0);

      // Overflow: nine pushes saturate at DEPTH.
      for (int i = 0; i < 9; i++) send_num(16'(i + 1));
      check("overflow_depth", 32'(depth), 32'd8);
      send_eol(16'd0, 1'b1);
      collect("overflow", 0);

      // Reserved operator code flags an error without touching the stack.
      send_num(16'd4);
      send_op(OP_RSV);
      check("reserved_depth", 32'(depth), 32'd1);
      send_eol(16'd0, 1'b1);
      collect("reserved", 0);

      // Number and operator in the same cycle: number kept, operator dropped.
      send_num(16'd1);
      @(negedge clk);
      num       = 16'd3;
      num_ready = 1'b1;
      op        = OP_ADD;
      op_ready  = 1'b1;
      @(negedge clk);
      num_ready = 1'b0;
      op_ready  = 1'b0;
      repeat (gap) @(negedge clk);
      check("collide_depth", 32'(depth), 32'd2);
      send_op(OP_ADD);
      send_eol(16'd0, 1'b1);
      collect("collide", 0);

      // Overrun: a number strobed five cycles into DIV; stalled handshake.
      send_num(16'd100);
      send_num(16'd7);
      @(negedge clk);
      op       = OP_DIV;
      op_ready = 1'b1;
      @(negedge clk);
      op_ready = 1'b0;
      repeat (4) @(negedge clk);
      check("overrun_tok_ready", 32'(tok_ready), 32'd0);
      num       = 16'd55;
      num_ready = 1'b1;
      @(negedge clk);
      num_ready = 1'b0;
      repeat (gap) @(negedge clk);
      check("overrun_depth", 32'(depth), 32'd1);
      send_eol(16'd0, 1'b1);
      collect("overrun", 50);

      // Reset pulsed in cycle 8 of DIV aborts the operation.
      send_num(16'd100);
      send_num(16'd7);
      @(negedge clk);
      op       = OP_DIV;
      op_ready = 1'b1;
      @(negedge clk);
      op_ready = 1'b0;
      repeat (7) @(negedge clk);
      check("abort_in_div", 32'(tok_ready), 32'd0);
      rst_n = 1'b0;
      #1;
      check("abort_depth_async", 32'(depth), 32'd0);
      check("abort_tok_ready_async", 32'(tok_ready), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      seen_valid = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (result_valid === 1'b1) seen_valid = 1'b1;
      end
      check("abort_no_result", 32'(seen_valid), 32'd0);
      check("abort_depth", 32'(depth), 32'd0);
      send_num(16'd6);
      send_eol(16'd6, 1'b0);
      collect("after_abort", 0);

      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
